multi_channel_digit_serial_adder: RTL and testbench

Adds or subtracts CHANNELS independent operand streams in parallel. Each operand arrives least-significant digit first, DIGIT_W bits per cycle, in words of WORD_DIGITS digits. This block generalises the 1-bit serial adder with configurable digit width, channel count and word length, an add/subtract mode, a valid handshake with stalls, word framing and a per-word carry/borrow report. It sits between the serial operand shifters and the result deserialiser in the datapath.

---
 rtl/multi_channel_digit_serial_adder_pkg.sv | 14 +
 rtl/multi_channel_digit_serial_adder_slice.sv | 63 ++++++
 rtl/multi_channel_digit_serial_adder.sv | 112 +++++++++++
 tb/tb_multi_channel_digit_serial_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_digit_serial_adder_pkg.sv
// Shared types for the multi-channel digit-serial adder: add/sub mode and word framing state.
package serial_adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_t;

    typedef enum logic {
        WORD_START = 1'b0,
        IN_WORD    = 1'b1
    } frame_state_t;

endpackage

// File: rtl/multi_channel_digit_serial_adder_slice.sv
// One adder lane: digit add/subtract with a stored carry between digits of a word.
// Overflow output only exists when MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN is defined.
module digit_serial_slice
    import serial_adder_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_accept,
    input  logic               i_first,
    input  logic               i_last,
    input  logic               i_clear,
    input  logic               i_mode,
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    output logic [DIGIT_W-1:0] o_sum,
`ifdef MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN
    output logic               o_ovf,
`endif
    output logic               o_carry
);

    logic               r_carry;
    logic [DIGIT_W-1:0] w_b;
    logic               w_cin;
    logic [DIGIT_W:0]   w_full;

    // Subtraction is a + ~b + 1; the +1 enters as the digit-0 carry-in.
    assign w_b    = i_b ^ {DIGIT_W{i_mode}};
    assign w_cin  = i_first ? i_mode : r_carry;
    assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{DIGIT_W{1'b0}}, w_cin};

`ifdef MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN
    logic w_c_into_msb;
    assign w_c_into_msb = w_full[DIGIT_W-1] ^ i_a[DIGIT_W-1] ^ w_b[DIGIT_W-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ovf <= 1'b0;
        end else if (!i_clear && i_accept && i_last) begin
            o_ovf <= w_c_into_msb ^ w_full[DIGIT_W];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_carry <= 1'b0;
            o_sum   <= '0;
            o_carry <= 1'b0;
        end else if (i_clear) begin
            r_carry <= 1'b0;
        end else if (i_accept) begin
            r_carry <= w_full[DIGIT_W];
            o_sum   <= w_full[DIGIT_W-1:0];
            if (i_last) begin
                o_carry <= w_full[DIGIT_W];
            end
        end
    end

endmodule

// File: rtl/multi_channel_digit_serial_adder.sv
// Multi-channel digit-serial adder/subtractor: shared digit counter, framing FSM and latched mode.
// Optional signed-overflow port enabled by MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN.
module multi_channel_digit_serial_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT_W     = 1,
    parameter int CHANNELS    = 2,
    parameter int WORD_DIGITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic                        clear,
    input  logic                        sub,
    input  logic [CHANNELS*DIGIT_W-1:0] a,
    input  logic [CHANNELS*DIGIT_W-1:0] b,
    output logic                        valid_out,
    output logic                        first_out,
    output logic                        last_out,
    output logic [CHANNELS*DIGIT_W-1:0] sum,
    output logic [CHANNELS-1:0]         carry_out,
`ifdef MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN
    output logic [CHANNELS-1:0]         ovf_out,
`endif
    output logic                        o_dbg_state
);

    localparam int               CNT_W    = $clog2(WORD_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);

    frame_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    mode_t            r_mode;

    logic w_first;
    logic w_last;
    logic w_accept;
    logic w_mode;

    // Handshake: a digit is taken on any cycle with valid_in high and clear low;
    // there is no backpressure, the block accepts one digit per cycle.
    assign w_first  = (r_state == WORD_START);
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_accept = valid_in && !clear;
    assign w_mode   = w_first ? sub : (r_mode == MODE_SUB);

    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= WORD_START;
            r_cnt     <= '0;
            r_mode    <= MODE_ADD;
            valid_out <= 1'b0;
            first_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= w_accept;
            if (clear) begin
                r_state <= WORD_START;
                r_cnt   <= '0;
            end else if (valid_in) begin
                first_out <= w_first;
                last_out  <= w_last;
                case (r_state)
                    WORD_START: begin
                        r_mode  <= mode_t'(sub);
                        r_state <= IN_WORD;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                    IN_WORD: begin
                        if (w_last) begin
                            r_state <= WORD_START;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= WORD_START;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_lane
            digit_serial_slice #(
                .DIGIT_W (DIGIT_W)
            ) u_slice (
                .clk      (clk),
                .rst      (rst),
                .i_accept (w_accept),
                .i_first  (w_first),
                .i_last   (w_last),
                .i_clear  (clear),
                .i_mode   (w_mode),
                .i_a      (a[k*DIGIT_W +: DIGIT_W]),
                .i_b      (b[k*DIGIT_W +: DIGIT_W]),
                .o_sum    (sum[k*DIGIT_W +: DIGIT_W]),
`ifdef MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN
                .o_ovf    (ovf_out[k]),
`endif
                .o_carry  (carry_out[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_digit_serial_adder.sv
// Bench for multi_channel_digit_serial_adder: a 1-bit-digit and a 4-bit-digit instance,
// checked digit by digit against whole-word arithmetic.
`timescale 1ns/1ps
module tb_multi_channel_digit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v0, v1, clr0, clr1, sub_in;
    logic [7:0] a_bus, b_bus;
    logic       vo0, fo0, lo0, vo1, fo1, lo1, dbg0, dbg1;
    logic [1:0] sum0, co0, co1;
    logic [7:0] sum1;
`ifdef MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN
    logic [1:0] ovf0, ovf1;
`endif

    multi_channel_digit_serial_adder #(.DIGIT_W(1), .CHANNELS(2), .WORD_DIGITS(16)) u_dut0 (
        .clk(clk), .rst(rst), .valid_in(v0), .clear(clr0), .sub(sub_in),
        .a(a_bus[1:0]), .b(b_bus[1:0]),
        .valid_out(vo0), .first_out(fo0), .last_out(lo0), .sum(sum0), .carry_out(co0),
`ifdef MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN
        .ovf_out(ovf0),
`endif
        .o_dbg_state(dbg0)
    );

    multi_channel_digit_serial_adder #(.DIGIT_W(4), .CHANNELS(2), .WORD_DIGITS(4)) u_dut1 (
        .clk(clk), .rst(rst), .valid_in(v1), .clear(clr1), .sub(sub_in),
        .a(a_bus), .b(b_bus),
        .valid_out(vo1), .first_out(fo1), .last_out(lo1), .sum(sum1), .carry_out(co1),
`ifdef MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN
        .ovf_out(ovf1),
`endif
        .o_dbg_state(dbg1)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] hold_sum[2];
    logic       hold_first[2];
    logic       hold_last[2];
    logic [1:0] hold_carry[2];
    logic [1:0] hold_ovf[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole-word reference: 17-bit result, bit 16 is carry (subtract: 1 = no borrow).
    function automatic logic [16:0] word_result(input logic [15:0] x, input logic [15:0] y, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + 17'd1;
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic logic word_ovf(input logic [15:0] x, input logic [15:0] y, input logic s,
                                      input logic [15:0] r);
        if (s) return (x[15] != y[15]) && (r[15] != x[15]);
        return (x[15] == y[15]) && (r[15] != x[15]);
    endfunction

    function automatic logic got_v(input int sel);     return sel ? vo1 : vo0; endfunction
    function automatic logic got_f(input int sel);     return sel ? fo1 : fo0; endfunction
    function automatic logic got_l(input int sel);     return sel ? lo1 : lo0; endfunction
    function automatic logic [7:0] got_s(input int sel); return sel ? sum1 : {6'b0, sum0}; endfunction
    function automatic logic [1:0] got_c(input int sel); return sel ? co1 : co0; endfunction
`ifdef MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN
    function automatic logic [1:0] got_o(input int sel); return sel ? ovf1 : ovf0; endfunction
`endif

    task automatic set_ctl(input int sel, input logic v, input logic c);
        v0   = (sel == 0) && v;
        v1   = (sel == 1) && v;
        clr0 = (sel == 0) && c;
        clr1 = (sel == 1) && c;
    endtask

    task automatic check_hold(input int sel, input string tag);
        check_val({tag, "_valid"}, 32'(got_v(sel)), 32'd0);
        check_val({tag, "_sum"},   32'(got_s(sel)), 32'(hold_sum[sel]));
        check_val({tag, "_first"}, 32'(got_f(sel)), 32'(hold_first[sel]));
        check_val({tag, "_last"},  32'(got_l(sel)), 32'(hold_last[sel]));
        check_val({tag, "_carry"}, 32'(got_c(sel)), 32'(hold_carry[sel]));
`ifdef MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN
        check_val({tag, "_ovf"},   32'(got_o(sel)), 32'(hold_ovf[sel]));
`endif
    endtask

    task automatic idle_cycle(input int sel);
        set_ctl(sel, 1'b0, 1'b0);
        a_bus  = 8'($urandom);
        b_bus  = 8'($urandom);
        sub_in = 1'($urandom_range(1));
        @(posedge clk); #1;
        check_hold(sel, "stall");
    endtask

    task automatic clear_holds();
        for (int s = 0; s < 2; s++) begin
            hold_sum[s] = '0; hold_first[s] = 1'b0; hold_last[s] = 1'b0;
            hold_carry[s] = '0; hold_ovf[s] = '0;
        end
    endtask

    // abort_kind: 0 none, 1 clear with valid at digit abort_at, 2 async reset at digit abort_at.
    task automatic run_word(input int sel, input logic [31:0] wa, input logic [31:0] wb, input logic s,
                            input int stall_pct, input int abort_at, input int abort_kind);
        int          dw, nd;
        logic [16:0] r[2];
        logic [1:0]  exp_c, exp_o;
        logic [7:0]  d;
        dw = sel ? 4 : 1;
        nd = sel ? 4 : 16;
        for (int k = 0; k < 2; k++) begin
            r[k]     = word_result(wa[k*16 +: 16], wb[k*16 +: 16], s);
            exp_c[k] = r[k][16];
            exp_o[k] = word_ovf(wa[k*16 +: 16], wb[k*16 +: 16], s, r[k][15:0]);
        end
        for (int i = 0; i < nd; i++) begin
            while ($urandom_range(99) < stall_pct) idle_cycle(sel);
            a_bus = '0; b_bus = '0; d = '0;
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < dw; j++) begin
                    a_bus[k*dw + j] = wa[k*16 + i*dw + j];
                    b_bus[k*dw + j] = wb[k*16 + i*dw + j];
                    d[k*dw + j]     = r[k][i*dw + j];
                end
            end
            sub_in = (i == 0) ? s : ~s;
            if (i == abort_at && abort_kind == 1) begin
                set_ctl(sel, 1'b1, 1'b1);
                @(posedge clk); #1;
                set_ctl(sel, 1'b0, 1'b0);
                check_hold(sel, "clear");
                return;
            end
            if (i == abort_at && abort_kind == 2) begin
                set_ctl(sel, 1'b0, 1'b0);
                #2 rst = 1'b0;
                #1;
                clear_holds();
                check_hold(0, "rst_d0");
                check_hold(1, "rst_d1");
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            set_ctl(sel, 1'b1, 1'b0);
            exp_q.push_back(d);
            @(posedge clk); #1;
            set_ctl(sel, 1'b0, 1'b0);
            check_val("valid", 32'(got_v(sel)), 32'd1);
            if (exp_q.size() > 0) check_val("sum", 32'(got_s(sel)), 32'(exp_q.pop_front()));
            check_val("first", 32'(got_f(sel)), 32'(i == 0));
            check_val("last",  32'(got_l(sel)), 32'(i == nd - 1));
            hold_sum[sel]   = d;
            hold_first[sel] = (i == 0);
            hold_last[sel]  = (i == nd - 1);
            if (i == nd - 1) begin
                check_val("carry", 32'(got_c(sel)), 32'(exp_c));
                hold_carry[sel] = exp_c;
`ifdef MULTI_CHANNEL_DIGIT_SERIAL_ADDER_OVF_EN
                check_val("ovf", 32'(got_o(sel)), 32'(exp_o));
`endif
                hold_ovf[sel] = exp_o;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        set_ctl(0, 1'b0, 1'b0);
        sub_in = 1'b0; a_bus = '0; b_bus = '0;
        clear_holds();
        repeat (2) @(posedge clk);
        #1;
        check_hold(0, "reset0");
        check_hold(1, "reset1");
        @(negedge clk);
        rst = 1'b1;

        // ch0 0x8192+0x2154, ch1 0xFFFF+0x0001
        run_word(0, {16'hFFFF, 16'h8192}, {16'h0001, 16'h2154}, 1'b0, 0, -1, 0);
        // subtract with sub toggled after digit 0
        run_word(0, {16'h0003, 16'h0005}, {16'h0005, 16'h0003}, 1'b1, 0, -1, 0);
        run_word(0, {16'h0005, 16'h0003}, {16'h0003, 16'h0005}, 1'b1, 0, -1, 0);
        // same add with ~50% stalls
        run_word(0, {16'hFFFF, 16'h8192}, {16'h0001, 16'h2154}, 1'b0, 50, -1, 0);
        // clear at digit 7, then a fresh word
        run_word(0, {16'h1234, 16'h8192}, {16'h4321, 16'h2154}, 1'b0, 0, 7, 1);
        run_word(0, {16'h0001, 16'h0001}, {16'h0001, 16'h0001}, 1'b0, 0, -1, 0);
        // async reset at digit 5, then a full word from digit 0
        run_word(0, {16'hAAAA, 16'h8192}, {16'h5555, 16'h2154}, 1'b0, 0, 5, 2);
        run_word(0, {16'hFFFF, 16'h8192}, {16'h0001, 16'h2154}, 1'b0, 0, -1, 0);

        // 4-bit digits: back-to-back words, first/last on digits 0 and 3
        run_word(1, {16'h1234, 16'h7FFF}, {16'h0FFF, 16'h0001}, 1'b0, 0, -1, 0);
        run_word(1, {16'h8000, 16'h0003}, {16'h0001, 16'h0005}, 1'b1, 0, -1, 0);
        run_word(1, {16'hFFFF, 16'h7FFF}, {16'h0001, 16'hFFFF}, 1'b1, 0, -1, 0);

        for (int n = 0; n < 6; n++) begin
            run_word(0, $urandom, $urandom, 1'($urandom_range(1)), 25, -1, 0);
            run_word(1, $urandom, $urandom, 1'($urandom_range(1)), 25, -1, 0);
        end
        idle_cycle(0);
        idle_cycle(1);
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
